core_fetch_pipe: RTL and testbench

//  Parametrised successor fetch stage. Sits between the branch/porch logic and the instruction bus.
//  - Keeps up to MAX_INFLIGHT in-order bus reads outstanding.
//  - Buffers returned words with their PCs in a 2**PREFETCH_ORDER FIFO.
//  - Counts and drops stale responses after a flush, however many are in flight.
//  - Presents one instruction per unstalled cycle.

---
 rtl/core_fetch_pipe.sv | 178 +++++++++++++++++
 tb/tb_core_fetch_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch_pipe.sv
// Fetch stage: keeps in-order instruction-bus reads in flight, buffers {pc, insn} in a FIFO, drops stale responses after a redirect.
// Optional perf counters (perf_dropped, perf_bubbles) are built when CORE_FETCH_PERF_EN is defined.
module core_fetch_pipe #(
    parameter int unsigned PREFETCH_ORDER = 2,
    parameter int unsigned MAX_INFLIGHT   = 2,
    parameter int unsigned ADDR_W         = 30,
    parameter int unsigned DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch,
    input  logic [ADDR_W-1:0] target,
    input  logic              prefetch_flush,
    input  logic [ADDR_W-1:0] porch_insn_pc,
    input  logic              fetch_ready,
    input  logic              fetched,
    input  logic [DATA_W-1:0] fetch_data,
    output logic              fetch,
    output logic [ADDR_W-1:0] addr,
    output logic              flush,
    output logic [ADDR_W-1:0] fetch_head,
    output logic [DATA_W-1:0] insn,
    output logic [ADDR_W-1:0] insn_pc,
    output logic              nop
`ifdef CORE_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_dropped,
    output logic [31:0]       perf_bubbles
`endif
);

    localparam int unsigned DEPTH = 1 << PREFETCH_ORDER;
    localparam int unsigned PTR_W = PREFETCH_ORDER;
    localparam int unsigned CNT_W = PREFETCH_ORDER + 1;
    // Headroom above MAX_INFLIGHT: back-to-back redirects can stack stale reads on top of live ones.
    localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1) + 4;
    localparam int unsigned SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [INF_W-1:0]  r_inflight;
    logic [INF_W-1:0]  r_discard;
    logic [CNT_W-1:0]  r_fifo_cnt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [DATA_W-1:0] r_insn;
    logic [ADDR_W-1:0] r_insn_pc;
    logic              r_nop;

    logic              w_flush;
    logic [ADDR_W-1:0] w_head;
    logic [INF_W-1:0]  w_live;
    logic [CNT_W-1:0]  w_fifo_term;
    logic              w_fetch;
    logic              w_issue;
    logic [ADDR_W-1:0] w_addr;
    logic              w_drop;
    logic              w_resp_vld;
    logic              w_adv;
    logic              w_pop;
    logic              w_bypass;
    logic              w_push;

    // Redirect, credit and FIFO control
    always_comb begin
        w_flush     = branch | prefetch_flush;
        w_head      = branch ? target : porch_insn_pc;
        w_live      = r_inflight - r_discard;
        w_fifo_term = w_flush ? '0 : r_fifo_cnt;
        w_fetch     = rst_n
                    && (w_live < INF_W'(MAX_INFLIGHT))
                    && ((SUM_W'(w_fifo_term) + SUM_W'(w_live)) < SUM_W'(DEPTH));
        w_issue     = w_fetch & fetch_ready;
        w_addr      = w_flush ? w_head : r_addr;
        w_drop      = fetched & (w_flush | (r_discard != '0));
        w_resp_vld  = fetched & ~w_drop;
        w_adv       = ~stall & ~w_flush;
        w_pop       = w_adv & (r_fifo_cnt != '0);
        w_bypass    = w_adv & (r_fifo_cnt == '0) & w_resp_vld;
        w_push      = w_resp_vld & ~w_bypass;
    end

    assign fetch      = w_fetch;
    assign addr       = w_addr;
    assign flush      = w_flush;
    assign fetch_head = w_head;
    assign insn       = r_insn;
    assign insn_pc    = r_insn_pc;
    assign nop        = r_nop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_resp_pc  <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_addr     <= w_addr + ADDR_W'(w_issue);
            r_inflight <= r_inflight + INF_W'(w_issue) - INF_W'(fetched);
            if (w_flush) begin
                // Every read already on the bus is stale, including one returning now.
                r_discard  <= r_inflight - INF_W'(fetched);
                r_resp_pc  <= w_head;
                r_fifo_cnt <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (fetched && (r_discard != '0)) begin
                    r_discard <= r_discard - INF_W'(1);
                end
                r_resp_pc  <= r_resp_pc + ADDR_W'(w_resp_vld);
                r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
                r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
                r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
            r_fifo_data[r_wr_ptr] <= fetch_data;
        end
    end

    // Output register: FIFO head first, else same-cycle bypass of the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_insn    <= '0;
            r_insn_pc <= '0;
            r_nop     <= 1'b1;
        end else if (w_flush) begin
            r_nop <= 1'b1;
        end else if (!stall) begin
            if (w_pop) begin
                r_insn    <= r_fifo_data[r_rd_ptr];
                r_insn_pc <= r_fifo_pc[r_rd_ptr];
                r_nop     <= 1'b0;
            end else if (w_bypass) begin
                r_insn    <= fetch_data;
                r_insn_pc <= r_resp_pc;
                r_nop     <= 1'b0;
            end else begin
                r_nop <= 1'b1;
            end
        end
    end

`ifdef CORE_FETCH_PERF_EN
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_dropped <= '0;
            r_perf_bubbles <= '0;
        end else begin
            r_perf_dropped <= r_perf_dropped + 32'(w_drop);
            r_perf_bubbles <= r_perf_bubbles + 32'(~stall & r_nop);
        end
    end

    assign perf_dropped = r_perf_dropped;
    assign perf_bubbles = r_perf_bubbles;
`endif

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(fetched && (r_inflight == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_fifo_cnt == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_core_fetch_pipe.sv
// Bench for core_fetch_pipe: 1-cycle in-order memory returning mem[a]=a*4 (holdable), scoreboard of expected {pc, insn}.
module tb_core_fetch_pipe;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          branch;
    logic [AW-1:0] target;
    logic          prefetch_flush;
    logic [AW-1:0] porch_insn_pc;
    logic          fetch_ready;
    logic          fetched;
    logic [DW-1:0] fetch_data;
    logic          fetch;
    logic [AW-1:0] addr;
    logic          flush;
    logic [AW-1:0] fetch_head;
    logic [DW-1:0] insn;
    logic [AW-1:0] insn_pc;
    logic          nop;
`ifdef CORE_FETCH_PERF_EN
    logic [31:0]   perf_dropped;
    logic [31:0]   perf_bubbles;
`endif

    core_fetch_pipe dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch         (branch),
        .target         (target),
        .prefetch_flush (prefetch_flush),
        .porch_insn_pc  (porch_insn_pc),
        .fetch_ready    (fetch_ready),
        .fetched        (fetched),
        .fetch_data     (fetch_data),
        .fetch          (fetch),
        .addr           (addr),
        .flush          (flush),
        .fetch_head     (fetch_head),
        .insn           (insn),
        .insn_pc        (insn_pc),
        .nop            (nop)
`ifdef CORE_FETCH_PERF_EN
        ,
        .perf_dropped   (perf_dropped),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic          live;
    } req_t;

    typedef struct {
        logic          br;
        logic [AW-1:0] tgt;
        logic          pf;
        logic [AW-1:0] porch;
        logic [AW-1:0] exp_head;
    } redir_t;

    req_t          mem_q[$];
    logic [AW-1:0] exp_q[$];
    redir_t        vec[4];

    int            checks;
    int            errors;
    logic          mem_hold;
    logic [AW-1:0] exp_addr;
    logic          prev_load, prev_stall, prev_flush, prev_nop;
    logic [AW-1:0] prev_pc;
    logic          s_fetch, s_flush, s_nop;
    logic [AW-1:0] s_addr, s_head, s_pc;
    logic [DW-1:0] s_insn;
    logic          got_new;
    logic [AW-1:0] got_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample and score at negedge, advance model, then drive the memory response.
    task automatic tick();
        logic          cur_flush;
        logic [AW-1:0] head;
        logic [AW-1:0] ea;
        logic [AW-1:0] e;
        logic [DW-1:0] ed;
        logic          issue;
        req_t          r;
        @(negedge clk);
        s_fetch = fetch;  s_addr = addr;  s_flush = flush; s_head = fetch_head;
        s_nop   = nop;    s_pc   = insn_pc; s_insn = insn;
        got_new = 1'b0;
        if (!rst_n) begin
            mem_q.delete();
            exp_q.delete();
            exp_addr   = '0;
            prev_load  = 1'b0;
            prev_stall = 1'b0;
            prev_flush = 1'b0;
        end else begin
            if (prev_load && !s_nop) begin
                got_new = 1'b1;
                got_pc  = s_pc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL insn_unexpected: got pc %0h expected no instruction", s_pc);
                end else begin
                    e  = exp_q.pop_front();
                    ed = DW'(e) << 2;
                    chk("insn_pc", s_pc, e);
                    chk("insn", s_insn, ed);
                end
            end
            if (prev_stall && !prev_flush) begin
                chk("hold_pc", s_pc, prev_pc);
                chk("hold_nop", s_nop, prev_nop);
            end
            cur_flush = branch | prefetch_flush;
            head      = branch ? target : porch_insn_pc;
            chk("flush", s_flush, cur_flush);
            if (cur_flush) chk("fetch_head", s_head, head);
            ea = cur_flush ? head : exp_addr;
            if (s_fetch) chk("addr", s_addr, ea);
            issue = s_fetch & fetch_ready;
            if (cur_flush) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].live = 1'b0;
            end
            if (fetched && mem_q.size() > 0) begin
                r = mem_q.pop_front();
                if (r.live) exp_q.push_back(r.a);
            end
            if (issue) begin
                r.a    = ea;
                r.live = 1'b1;
                mem_q.push_back(r);
            end
            exp_addr   = ea + AW'(issue);
            prev_load  = ~stall & ~cur_flush;
            prev_stall = stall;
            prev_flush = cur_flush;
        end
        prev_pc  = s_pc;
        prev_nop = s_nop;
        @(posedge clk);
        #1;
        if (mem_q.size() > 0 && !mem_hold) begin
            fetched    = 1'b1;
            fetch_data = DW'(mem_q[0].a) << 2;
        end else begin
            fetched    = 1'b0;
            fetch_data = '0;
        end
    endtask

    // Wait (bounded) for the next presented instruction; output must read nop meanwhile.
    task automatic wait_valid(input logic [AW-1:0] exp, input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (!got_new) chk({name, "_gap_nop"}, s_nop, 1);
        end while (!got_new && n < 20);
        if (got_new) chk(name, got_pc, exp);
        else begin
            checks++;
            errors++;
            $display("FAIL %s: got no instruction within 20 cycles expected pc %0h", name, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int bub;
`ifdef CORE_FETCH_PERF_EN
        logic [31:0] base;
`endif
        vec[0] = '{br: 1'b1, tgt: 30'h200,      pf: 1'b0, porch: 30'h777, exp_head: 30'h200};
        vec[1] = '{br: 1'b0, tgt: 30'h123,      pf: 1'b1, porch: 30'h300, exp_head: 30'h300};
        vec[2] = '{br: 1'b1, tgt: 30'h40,       pf: 1'b1, porch: 30'h80,  exp_head: 30'h40};
        vec[3] = '{br: 1'b1, tgt: 30'h3FFFFFFF, pf: 1'b0, porch: 30'h10,  exp_head: 30'h3FFFFFFF};

        checks = 0; errors = 0;
        rst_n = 1'b0; stall = 1'b0; branch = 1'b0; target = '0;
        prefetch_flush = 1'b0; porch_insn_pc = '0; fetch_ready = 1'b1;
        fetched = 1'b0; fetch_data = '0; mem_hold = 1'b0; exp_addr = '0;
        prev_load = 1'b0; prev_stall = 1'b0; prev_flush = 1'b0; prev_nop = 1'b1; prev_pc = '0;

        // Reset state and first fetch
        repeat (5) begin
            tick();
            chk("rst_fetch", s_fetch, 0);
            chk("rst_nop", s_nop, 1);
            chk("rst_pc", s_pc, 0);
        end
        rst_n = 1'b1;
        tick();
        chk("rel_fetch", s_fetch, 1);
        chk("rel_addr", s_addr, 0);
        tick();
        tick();
        chk("first_nop", s_nop, 0);
        chk("first_pc", s_pc, 0);

        // Free run
        bub = 0;
        repeat (20) begin
            tick();
            if (s_nop) bub++;
        end
        chk("freerun_bubbles", bub, 0);

        // Stall fills the FIFO, then drains without gaps
        stall = 1'b1;
        repeat (10) tick();
        chk("stall_fetch", s_fetch, 0);
        stall = 1'b0;
        repeat (8) begin
            tick();
            chk("drain_nop", s_nop, 0);
        end

        // Branch with two reads held on the bus
        mem_hold = 1'b1;
        repeat (3) tick();
        chk("credit_cap_fetch", s_fetch, 0);
`ifdef CORE_FETCH_PERF_EN
        base = perf_dropped;
`endif
        branch = 1'b1; target = 30'h100;
        tick();
        branch = 1'b0; mem_hold = 1'b0;
        wait_valid(30'h100, "br_held_pc", n);
`ifdef CORE_FETCH_PERF_EN
        chk("perf_dropped", perf_dropped - base, 2);
`endif
        repeat (4) tick();

        // Redirect table, incl. simultaneous branch/prefetch_flush and address wrap
        for (int i = 0; i < 4; i++) begin
            repeat (4) tick();
            branch = vec[i].br; target = vec[i].tgt;
            prefetch_flush = vec[i].pf; porch_insn_pc = vec[i].porch;
            tick();
            chk("redir_head", s_head, vec[i].exp_head);
            branch = 1'b0; prefetch_flush = 1'b0;
            wait_valid(vec[i].exp_head, "redir_pc", n);
            repeat (3) tick();
        end

        // Branch coinciding with a response, bus not ready afterwards
        repeat (4) tick();
        branch = 1'b1; target = 30'h500;
        tick();
        chk("flush_cycle_fetch", s_fetch, 1);
        branch = 1'b0; fetch_ready = 1'b0;
        wait_valid(30'h500, "br_resp_pc", n);
        if (n < 3) repeat (3 - n) tick();
        fetch_ready = 1'b1;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
